// File: rtl/tick_monitor_pkg.sv
// Shared types and default constants for the tick monitor.
// Optional build macro: TICK_MONITOR_STICKY_EN (see tick_monitor.sv).
package tick_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        LOCKED,
        FAULT
    } tm_state_e;

    localparam int DEF_PERIOD = 20001;
    localparam int DEF_TOL    = 2;
    localparam int DEF_LOCK_N = 4;
    localparam int DEF_CBITS  = 16;

    // Bits needed to hold a count from 0 up to n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tick_interval_timer.sv
// Saturating tick-to-tick interval timer with window compare.
// Judges the running interval on each tick and flags a missed tick.
module tick_interval_timer
    import tick_monitor_pkg::*;
#(
    parameter int PERIOD = DEF_PERIOD,
    parameter int TOL    = DEF_TOL,
    parameter int CBITS  = DEF_CBITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             arm_i,
    output logic [CBITS-1:0] gap_o,
    output logic             early_hit_o,
    output logic             good_hit_o,
    output logic             late_hit_o
);

    // Window bounds in one extra bit so a low bound never underflows.
    localparam logic [CBITS:0] LO_V =
        (PERIOD > TOL) ? (CBITS+1)'(PERIOD - TOL) : '0;
    localparam logic [CBITS:0] HI_V   = (CBITS+1)'(PERIOD + TOL);
    localparam logic [CBITS:0] LATE_V = HI_V + (CBITS+1)'(1);

    logic [CBITS-1:0] timer_q, timer_d;
    logic [CBITS-1:0] gap_q, gap_d;
    logic [CBITS:0]   tmr_ext;

    assign tmr_ext = {1'b0, timer_q};

    // Timer restarts at 1 on a tick, otherwise counts up and saturates.
    always_comb begin
        timer_d = timer_q;
        if (tick_i) begin
            timer_d = CBITS'(1);
        end else if (timer_q != '1) begin
            timer_d = timer_q + CBITS'(1);
        end
    end

    // Capture the measured interval only once a previous tick exists.
    always_comb begin
        gap_d = gap_q;
        if (tick_i && arm_i) begin
            gap_d = timer_q;
        end
    end

    // Timer and captured gap registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
            gap_q   <= '0;
        end else begin
            timer_q <= timer_d;
            gap_q   <= gap_d;
        end
    end

    // Window classification; a tick on the overdue cycle wins over late.
    always_comb begin
        early_hit_o = tick_i && (tmr_ext < LO_V);
        good_hit_o  = tick_i && (tmr_ext >= LO_V) && (tmr_ext <= HI_V);
        late_hit_o  = !tick_i && (tmr_ext == LATE_V);
    end

    assign gap_o = gap_q;

endmodule

// File: rtl/tick_monitor.sv
// Tick period monitor: acquires lock on a periodic tick and flags faults.
// Build macro TICK_MONITOR_STICKY_EN: FAULT is held until reset.
module tick_monitor
    import tick_monitor_pkg::*;
#(
    parameter int PERIOD = DEF_PERIOD,
    parameter int TOL    = DEF_TOL,
    parameter int LOCK_N = DEF_LOCK_N,
    parameter int CBITS  = DEF_CBITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             err_i,
    output logic             locked,
    output logic             fault,
    output logic             early,
    output logic             late,
    output logic [CBITS-1:0] gap,
    output logic [15:0]      tick_cnt
);

    localparam int GW = cnt_width(LOCK_N);
    localparam logic [GW-1:0] LOCK_V = GW'(LOCK_N);

    tm_state_e state_q, state_d;
    logic [GW-1:0] good_q, good_d;
    logic [GW-1:0] good_inc;
    logic [15:0]   tick_cnt_q, tick_cnt_d;
    logic          early_q, early_d;
    logic          late_q, late_d;
    logic          armed;
    logic          early_hit, good_hit, late_hit;

    assign armed    = (state_q != IDLE);
    assign good_inc = good_q + GW'(1);

    tick_interval_timer #(
        .PERIOD (PERIOD),
        .TOL    (TOL),
        .CBITS  (CBITS)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .tick_i      (tick_i),
        .arm_i       (armed),
        .gap_o       (gap),
        .early_hit_o (early_hit),
        .good_hit_o  (good_hit),
        .late_hit_o  (late_hit)
    );

    // Lock/fault state machine and good-interval counter.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        unique case (state_q)
            IDLE: begin
                if (tick_i) begin
                    state_d = ACQ;
                    good_d  = '0;
                end
            end
            ACQ: begin
                if (err_i) begin
                    state_d = FAULT;
                    good_d  = '0;
                end else if (good_hit) begin
                    if (good_inc >= LOCK_V) begin
                        state_d = LOCKED;
                        good_d  = '0;
                    end else begin
                        good_d = good_inc;
                    end
                end else if (early_hit) begin
                    good_d = '0;
                end else if (late_hit) begin
                    state_d = IDLE;
                    good_d  = '0;
                end
            end
            LOCKED: begin
                if (err_i || early_hit || late_hit) begin
                    state_d = FAULT;
                    good_d  = '0;
                end
            end
            FAULT: begin
`ifdef TICK_MONITOR_STICKY_EN
                state_d = FAULT;
`else
                if (tick_i && !err_i) begin
                    state_d = ACQ;
                    good_d  = '0;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                good_d  = '0;
            end
        endcase
    end

    // Event pulses and the free-running tick counter.
    always_comb begin
        early_d    = early_hit && armed;
        late_d     = late_hit && armed;
        tick_cnt_d = tick_cnt_q + {15'd0, tick_i};
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            good_q     <= '0;
            tick_cnt_q <= '0;
            early_q    <= 1'b0;
            late_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_q     <= good_d;
            tick_cnt_q <= tick_cnt_d;
            early_q    <= early_d;
            late_q     <= late_d;
        end
    end

    assign locked   = (state_q == LOCKED);
    assign fault    = (state_q == FAULT);
    assign early    = early_q;
    assign late     = late_q;
    assign tick_cnt = tick_cnt_q;

endmodule

// File: tb/tb_tick_monitor.sv
// Self-checking bench for tick_monitor (PERIOD=10, TOL=1, LOCK_N=2).
// Honours TICK_MONITOR_STICKY_EN for the expected fault behaviour.
module tb_tick_monitor;

    localparam int P  = 10;
    localparam int T  = 1;
    localparam int L  = 2;
    localparam int CB = 16;

`ifdef TICK_MONITOR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic          err = 1'b0;
    logic          locked, fault, early, late;
    logic [CB-1:0] gap;
    logic [15:0]   tick_cnt;

    typedef struct {
        bit lk;
        bit ft;
        bit er;
        bit lt;
        int gp;
        int tc;
    } snap_t;

    snap_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    tc_exp = 0;

    always #5 clk = ~clk;

    tick_monitor #(
        .PERIOD (P),
        .TOL    (T),
        .LOCK_N (L),
        .CBITS  (CB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_i   (tick),
        .err_i    (err),
        .locked   (locked),
        .fault    (fault),
        .early    (early),
        .late     (late),
        .gap      (gap),
        .tick_cnt (tick_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_early"}, early, 0);
        chk({tag, "_late"}, late, 0);
        chk({tag, "_gap"}, gap, 0);
        chk({tag, "_tcnt"}, tick_cnt, 0);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        tick = 1'b0;
        err  = 1'b0;
        step();
        step();
        rst    = 1'b0;
        tc_exp = 0;
        chk_zero("rst");
    endtask

    // Idle for n cycles; late must pulse exactly on step late_at (0: never).
    task automatic do_wait(input int n, input int late_at);
        for (int i = 1; i <= n; i++) begin
            step();
            chk("wait_late", late, (i == late_at) ? 1 : 0);
            chk("wait_early", early, 0);
        end
    endtask

    // Tick n cycles after the previous tick and score the result.
    task automatic do_tick(input int n, input bit e, input int late_at,
                           input bit lk, input bit ft, input bit er,
                           input int gp);
        snap_t s;
        snap_t o;
        for (int i = 1; i < n; i++) begin
            step();
            chk("idle_late", late, (i == late_at) ? 1 : 0);
            chk("idle_early", early, 0);
        end
        tick   = 1'b1;
        err    = e;
        tc_exp = tc_exp + 1;
        s = '{lk: lk, ft: ft, er: er, lt: 1'b0, gp: gp, tc: tc_exp};
        exp_q.push_back(s);
        step();
        tick = 1'b0;
        err  = 1'b0;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            o = exp_q.pop_front();
            chk("locked", locked, o.lk);
            chk("fault", fault, o.ft);
            chk("early", early, o.er);
            chk("late", late, o.lt);
            chk("gap", gap, o.gp);
            chk("tick_cnt", tick_cnt, o.tc);
        end
    endtask

    task automatic lock_up();
        do_tick(3, 0, 0, 0, 0, 0, 0);
        do_tick(10, 0, 0, 0, 0, 0, 10);
        do_tick(10, 0, 0, 1, 0, 0, 10);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Steady 10-cycle ticks lock after the third tick.
        lock_up();

        // Error with a tick while locked: fault, tick still counted.
        do_tick(10, 1, 0, 0, 1, 0, 10);
        do_tick(10, 0, 0, 0, STICKY, 0, 10);

        // Early tick while locked.
        do_reset();
        lock_up();
        do_tick(8, 0, 0, 0, 1, 1, 8);
        do_tick(10, 0, 0, 0, STICKY, 0, 10);
        do_tick(10, 0, 0, 0, STICKY, 0, 10);

        // Missing tick while locked: late on the 12th clock.
        do_reset();
        lock_up();
        do_wait(13, 12);
        chk("late_fault", fault, 1);
        chk("late_locked", locked, 0);
        do_tick(3, 0, 0, 0, STICKY, 0, 16);

        // Gaps at both window edges are good.
        do_reset();
        do_tick(3, 0, 0, 0, 0, 0, 0);
        do_tick(9, 0, 0, 0, 0, 0, 9);
        do_tick(11, 0, 0, 1, 0, 0, 11);
        do_tick(10, 0, 0, 1, 0, 0, 10);

        // Tick on the overdue cycle, then ACQ timeout back to IDLE.
        do_reset();
        do_tick(3, 0, 0, 0, 0, 0, 0);
        do_tick(12, 0, 0, 0, 0, 0, 12);
        do_wait(13, 12);
        chk("acq_to_idle_fault", fault, 0);
        chk("acq_to_idle_locked", locked, 0);
        do_tick(5, 0, 0, 0, 0, 0, 12);
        do_tick(8, 0, 0, 0, 0, 1, 8);

        // Reset mid-acquisition discards the partial interval.
        do_reset();
        do_tick(3, 0, 0, 0, 0, 0, 0);
        do_tick(10, 0, 0, 0, 0, 0, 10);
        do_wait(4, 0);
        rst = 1'b1;
        tick = 1'b1;
        step();
        rst    = 1'b0;
        tick   = 1'b0;
        tc_exp = 0;
        chk_zero("mid_rst");
        do_tick(6, 0, 0, 0, 0, 0, 0);
        do_tick(10, 0, 0, 0, 0, 0, 10);
        do_tick(10, 0, 0, 1, 0, 0, 10);

        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tick_monitor.md
TICK_MONITOR -- requirements
Module: tick_monitor

Interface
REQ-001 SHALL have parameter PERIOD, default 20001, meaning expected clk cycles between consecutive tick_i pulses.
REQ-002 SHALL have parameter TOL, default 2, meaning allowed +/- deviation in cycles from PERIOD.
REQ-003 SHALL have parameter LOCK_N, default 4, meaning consecutive good intervals required to lock.
REQ-004 SHALL have parameter CBITS, default 16, meaning width of the interval timer.
REQ-005 SHALL have port clk, input, 1, meaning clock; all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-007 SHALL have port tick_i, input, 1, meaning periodic single-cycle pulse from the upstream delay counter.
REQ-008 SHALL have port err_i, input, 1, meaning upstream overrun error.
REQ-009 SHALL have port locked, output, 1, meaning the state is LOCKED.
REQ-010 SHALL have port fault, output, 1, meaning the state is FAULT.
REQ-011 SHALL have port early, output, 1, meaning a one-cycle pulse when a tick arrives with gap < PERIOD-TOL.
REQ-012 SHALL have port late, output, 1, meaning a one-cycle pulse when the timer first exceeds PERIOD+TOL without a tick.
REQ-013 SHALL have port gap, output, CBITS, meaning the last measured tick-to-tick interval.
REQ-014 SHALL have port tick_cnt, output, 16, meaning the count of ticks seen since reset; wraps modulo 2^16.

Function
REQ-015 SHALL define gap as t1-t0 for ticks at cycles t0 and t1; the timer loads 1 on a tick cycle, else increments, saturating at 2^CBITS-1.
REQ-016 SHALL register gap and judge it on the tick cycle; outputs update one cycle after the tick (latency 1).
REQ-017 SHALL count an interval as good iff PERIOD-TOL <= gap <= PERIOD+TOL, evaluated in CBITS+1-bit unsigned arithmetic (no underflow when TOL >= PERIOD).
REQ-018 SHALL implement an FSM with states IDLE, ACQ, LOCKED and FAULT.
REQ-019 SHALL transition IDLE->ACQ on the first tick; no gap is judged for that tick.
REQ-020 SHALL, in ACQ, increment good_cnt on each good tick, clear it on an early tick, and go to LOCKED when good_cnt reaches LOCK_N.
REQ-021 SHALL, in ACQ, on late return to IDLE with good_cnt cleared.
REQ-022 SHALL transition LOCKED->FAULT on an early pulse, a late pulse, or err_i=1.
REQ-023 SHALL, in FAULT, leave FAULT only as defined in REQ-030/REQ-031.
REQ-024 SHALL, when err_i=1 in any state other than IDLE, enter FAULT, taking priority over a simultaneous tick.
REQ-025 SHALL assert late for exactly one cycle per missing interval (timer == PERIOD+TOL+1), never in IDLE.
REQ-026 SHALL, when tick_i=1 on the same cycle the timer reaches PERIOD+TOL+1, treat it as a tick, not a late event.
REQ-027 SHALL increment tick_cnt on every tick in every state.

Reset
REQ-028 SHALL, on rst=1, force state=IDLE, timer=0, good_cnt=0, gap=0, tick_cnt=0, and locked, fault, early, late=0, from the next edge.
REQ-029 SHALL give rst priority over tick_i and err_i on the same cycle; a reset mid-interval discards the partial interval.

Configuration
REQ-030 SHALL, with TICK_MONITOR_STICKY_EN defined, hold FAULT until rst.
REQ-031 SHALL, without TICK_MONITOR_STICKY_EN, make FAULT->ACQ on the next tick with err_i=0, with good_cnt cleared.

Structure
REQ-032 SHALL place the state enum (IDLE, ACQ, LOCKED, FAULT) and the default PERIOD/TOL/LOCK_N constants in package tick_monitor_pkg.
REQ-033 SHALL implement the saturating timer plus window compare as sub-module tick_interval_timer, which outputs gap, early_hit, good_hit and late_hit.
REQ-034 SHALL keep the FSM and counters in tick_monitor.

Verification (PERIOD=10, TOL=1, LOCK_N=2)
REQ-035 SHALL cover: ticks every 10 cycles -> locked=1 one cycle after the 3rd tick; gap=10; tick_cnt=3.
REQ-036 SHALL cover: locked, then a tick at gap 8 -> early pulse, fault=1; sticky build: fault stays high across further good ticks until rst.
REQ-037 SHALL cover: locked, then no tick -> late pulses exactly 12 cycles after the last tick; fault=1; a non-sticky build re-enters ACQ on the next tick.
REQ-038 SHALL cover: ticks at gaps 9, 11, 10 -> all good; locked after the second good gap.
REQ-039 SHALL cover: err_i=1 coincident with a tick while locked -> fault=1, tick_cnt still increments.
REQ-040 SHALL cover: rst asserted mid-ACQ for 1 cycle -> all outputs 0, IDLE; the next tick is not judged.
